// File: rtl/mxrv_ifu_pkg.sv
// Types shared by the instruction fetch unit and its fetch buffer.
//   ifu_state_e    fetch FSM state
//   fetch_entry_t  one fetch-buffer entry: {pc, inst}
`include "mxrv_defines.sv"

package mxrv_ifu_pkg;

   localparam int unsigned WordW = `PORT_WORD_WIDTH;

   typedef enum logic [1:0] {
      StBoot  = `IFU_BOOT,
      StRun   = `IFU_RUN,
      StDrain = `IFU_DRAIN
   } ifu_state_e;

   typedef struct packed {
      logic [WordW-1:0] pc;
      logic [WordW-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/mxrv_defines.sv
// Shared macro definitions for the mxrv core.
//   PORT_WORD_WIDTH    data/address word width on all core ports
//   INST_NOP           canonical NOP (addi x0, x0, 0)
//   RESET_PC_DEFAULT   default boot PC
//   IFU_BOOT/RUN/DRAIN fetch-unit state encodings
`ifndef MXRV_DEFINES_SV
`define MXRV_DEFINES_SV

`define PORT_WORD_WIDTH  32
`define INST_NOP         32'h0000_0013
`define RESET_PC_DEFAULT 32'h0000_0000

`define IFU_BOOT  2'd0
`define IFU_RUN   2'd1
`define IFU_DRAIN 2'd2

`endif

// File: rtl/mxrv_fetch_fifo.sv
// Synchronous fetch buffer holding {pc, inst} entries.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   flush_i    drop all entries (wins over push/pop)
//   push_i     write wdata_i
//   wdata_i    entry to write
//   pop_i      retire the head entry
//   rdata_o    head entry (valid when !empty_o)
//   empty_o    no entries
//   full_o     Depth entries held
//   count_o    current occupancy
module mxrv_fetch_fifo
   import mxrv_ifu_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  fetch_entry_t             wdata_i,
   input  logic                     pop_i,
   output fetch_entry_t             rdata_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(Depth):0]   count_o
);

   localparam int unsigned AddrW = $clog2(Depth);
   localparam int unsigned CntW  = AddrW + 1;
   localparam logic [AddrW-1:0] PtrOne = AddrW'(1);
   localparam logic [CntW-1:0]  CntOne = CntW'(1);

   fetch_entry_t     mem_q [Depth];
   logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CntW'(Depth));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so push into a full buffer is allowed then.
   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PtrOne;
         if (do_pop)  rd_ptr_d = rd_ptr_q + PtrOne;
         if (do_push && !do_pop) count_d = count_q + CntOne;
         if (!do_push && do_pop) count_d = count_q - CntOne;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by count_q.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/mxrv_ifu.sv
// Instruction fetch unit. Owns the PC, issues word fetches over a req/gnt/rvalid
// bus, buffers returned words and hands {inst, pc} to decode on valid/ready.
// Redirects flush the buffer; responses to requests issued before a redirect
// are counted in drop_cnt and discarded while the FSM sits in DRAIN.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req_o/addr_o        fetch request and word-aligned address
//   imem_gnt_i               request accepted
//   imem_rvalid_i/rdata_i    in-order response
//   redirect_i/redirect_pc_i flush and restart fetch at redirect_pc_i
//   inst_valid_o/ready_i     decode handshake
//   inst_data_o/inst_pc_o    instruction word and its PC
`include "mxrv_defines.sv"

module mxrv_ifu
   import mxrv_ifu_pkg::*;
#(
   parameter logic [`PORT_WORD_WIDTH-1:0] RESET_PC   = `RESET_PC_DEFAULT,
   parameter int unsigned                 FIFO_DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic                        imem_req_o,
   output logic [`PORT_WORD_WIDTH-1:0] imem_addr_o,
   input  logic                        imem_gnt_i,
   input  logic                        imem_rvalid_i,
   input  logic [`PORT_WORD_WIDTH-1:0] imem_rdata_i,
   input  logic                        redirect_i,
   input  logic [`PORT_WORD_WIDTH-1:0] redirect_pc_i,
   output logic                        inst_valid_o,
   input  logic                        inst_ready_i,
   output logic [`PORT_WORD_WIDTH-1:0] inst_data_o,
   output logic [`PORT_WORD_WIDTH-1:0] inst_pc_o
);

   localparam int unsigned      CntW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CntW-1:0]  CntOne      = CntW'(1);
   localparam logic [CntW:0]    CreditLimit = (CntW + 1)'(FIFO_DEPTH);
   localparam logic [WordW-1:0] PcStep      = WordW'(4);

   ifu_state_e       state_q, state_d;
   logic [WordW-1:0] pc_q, pc_d;
   logic [WordW-1:0] last_pc_q, last_pc_d;
   logic [CntW-1:0]  outstanding_q, outstanding_d;
   logic [CntW-1:0]  drop_cnt_q, drop_cnt_d;

   logic [CntW-1:0]  fifo_count;
   logic             fifo_empty, fifo_full, fifo_push, fifo_pop;
   fetch_entry_t     fifo_wdata, fifo_rdata;
   logic [CntW:0]    credit_used;
   logic             gnt_fire, rsp_drop;
   logic [WordW-1:0] rsp_pc;

   // Each request reserves a buffer slot until its word is popped, so a push
   // can never find the buffer full.
   assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding_q};
   assign imem_req_o  = (state_q == StRun) && (credit_used < CreditLimit);
   assign imem_addr_o = pc_q;
   assign gnt_fire    = imem_req_o && imem_gnt_i;

   assign rsp_drop  = (drop_cnt_q != '0) || (state_q == StBoot) || redirect_i;
   assign fifo_push = imem_rvalid_i && !rsp_drop;

   // When nothing is being dropped every outstanding request was issued
   // sequentially since the last redirect, so the oldest one sits this many
   // words behind pc_q.
   assign rsp_pc = pc_q - {{(WordW - CntW - 2){1'b0}}, outstanding_q, 2'b00};

   assign fifo_wdata   = '{pc: rsp_pc, inst: imem_rdata_i};
   assign inst_valid_o = !fifo_empty;
   assign fifo_pop     = inst_valid_o && inst_ready_i;
   assign inst_data_o  = fifo_empty ? `INST_NOP : fifo_rdata.inst;
   assign inst_pc_o    = fifo_empty ? last_pc_q : fifo_rdata.pc;

   mxrv_fetch_fifo #(
      .Depth (FIFO_DEPTH)
   ) u_fetch_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect_i),
      .push_i  (fifo_push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .count_o (fifo_count)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      outstanding_d = outstanding_q;
      drop_cnt_d    = drop_cnt_q;
      last_pc_d     = fifo_empty ? last_pc_q : fifo_rdata.pc;

      if (gnt_fire) begin
         pc_d          = pc_q + PcStep;
         outstanding_d = outstanding_d + CntOne;
      end
      if (imem_rvalid_i && (outstanding_q != '0)) outstanding_d = outstanding_d - CntOne;
      if (imem_rvalid_i && (drop_cnt_q != '0))    drop_cnt_d    = drop_cnt_q - CntOne;

      unique case (state_q)
         StBoot:  state_d = StRun;
         StRun:   state_d = StRun;
         StDrain: if (imem_rvalid_i && (drop_cnt_q == CntOne)) state_d = StRun;
         default: state_d = StBoot;
      endcase

      // Redirect sees this cycle's grant and response already accounted for.
      if (redirect_i) begin
         pc_d       = redirect_pc_i & ~WordW'(3);
         drop_cnt_d = outstanding_d;
         state_d    = (outstanding_d != '0) ? StDrain : StRun;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StBoot;
         pc_q          <= RESET_PC;
         last_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         last_pc_q     <= last_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   a_push_not_full : assert property (@(posedge clk) disable iff (rst)
      fifo_push |-> !fifo_full);

endmodule
